// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator core: opcodes, FSM states and
// the opcode classifier used by decode and memory completion.
package acc_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_ADDI  = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_SUBI  = 8'h04;
    localparam logic [7:0] OP_SHL   = 8'h05;
    localparam logic [7:0] OP_SHR   = 8'h06;
    localparam logic [7:0] OP_LOAD  = 8'h07;
    localparam logic [7:0] OP_LOADI = 8'h08;
    localparam logic [7:0] OP_STORE = 8'h09;
    localparam logic [7:0] OP_AND   = 8'h0A;
    localparam logic [7:0] OP_ANDI  = 8'h0B;
    localparam logic [7:0] OP_OR    = 8'h0C;
    localparam logic [7:0] OP_ORI   = 8'h0D;
    localparam logic [7:0] OP_XOR   = 8'h0E;
    localparam logic [7:0] OP_XORI  = 8'h0F;
    localparam logic [7:0] OP_JMP   = 8'h10;
    localparam logic [7:0] OP_JZ    = 8'h11;
    localparam logic [7:0] OP_JNZ   = 8'h12;
    localparam logic [7:0] OP_EXIT  = 8'h13;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MEM  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_LOAD  = 3'd1,
        CLS_STORE = 3'd2,
        CLS_IMM   = 3'd3,
        CLS_JUMP  = 3'd4,
        CLS_EXIT  = 3'd5
    } op_class_t;

    // Load-class ops read memory and combine the read data into acc.
    function automatic op_class_t op_class(input logic [7:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_LOAD, OP_AND, OP_OR, OP_XOR:
                cls = CLS_LOAD;
            OP_STORE:
                cls = CLS_STORE;
            OP_ADDI, OP_SUBI, OP_SHL, OP_SHR, OP_LOADI, OP_ANDI, OP_ORI, OP_XORI:
                cls = CLS_IMM;
            OP_JMP, OP_JZ, OP_JNZ:
                cls = CLS_JUMP;
            OP_EXIT:
                cls = CLS_EXIT;
            default:
                cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: result = f(op, acc, b), where b is either
// the zero-extended immediate or the memory read data.
module acc_alu
    import acc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [7:0]        i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
);

    localparam int SH_W = $clog2(DATA_W);

    always_comb begin
        o_result = i_acc;
        case (i_op)
            OP_ADD,  OP_ADDI:  o_result = i_acc + i_b;
            OP_SUB,  OP_SUBI:  o_result = i_acc - i_b;
            OP_SHL:            o_result = i_acc << i_b[SH_W-1:0];
            OP_SHR:            o_result = i_acc >> i_b[SH_W-1:0];
            OP_LOAD, OP_LOADI: o_result = i_b;
            OP_AND,  OP_ANDI:  o_result = i_acc & i_b;
            OP_OR,   OP_ORI:   o_result = i_acc | i_b;
            OP_XOR,  OP_XORI:  o_result = i_acc ^ i_b;
            default:           o_result = i_acc;
        endcase
    end

endmodule

// File: rtl/acc_core.sv
// Accumulator processor core with a valid/ready data-memory port.
// Optional retire trace outputs are enabled by defining ACC_CORE_TRACE_EN.
module acc_core
    import acc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 4,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RESETN,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    output logic              mem_valid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] acc,
    output logic              halted
`ifdef ACC_CORE_TRACE_EN
    ,
    output logic              trace_valid,
    output logic [PC_W-1:0]   trace_pc,
    output logic [15:0]       trace_instr,
    output logic [DATA_W-1:0] trace_acc
`endif
);

    state_t            r_state;
    state_t            w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_acc;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [7:0]        r_mem_op;

    logic [7:0]        w_op;
    logic [7:0]        w_operand;
    op_class_t         w_cls;
    logic [DATA_W-1:0] w_imm;
    logic [PC_W-1:0]   w_pc_inc;
    logic              w_jump_taken;
    logic [7:0]        w_alu_op;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu_res;
    logic [PC_W-1:0]   w_pc_next;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_issue;
    logic              w_retire;

    assign w_op      = imem_data[15:8];
    assign w_operand = imem_data[7:0];
    assign w_cls     = op_class(w_op);
    assign w_imm     = DATA_W'(w_operand);
    assign w_pc_inc  = r_pc + PC_W'(1);

    always_comb begin
        w_jump_taken = 1'b0;
        case (w_op)
            OP_JMP:  w_jump_taken = 1'b1;
            OP_JZ:   w_jump_taken = (r_acc == '0);
            OP_JNZ:  w_jump_taken = (r_acc != '0);
            default: w_jump_taken = 1'b0;
        endcase
    end

    // One ALU serves both the immediate path in RUN and load completion in MEM.
    assign w_alu_op = (r_state == ST_MEM) ? r_mem_op  : w_op;
    assign w_alu_b  = (r_state == ST_MEM) ? mem_rdata : w_imm;

    acc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (w_alu_op),
        .i_acc    (r_acc),
        .i_b      (w_alu_b),
        .o_result (w_alu_res)
    );

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_acc_next   = r_acc;
        w_issue      = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_retire = 1'b1;
                case (w_cls)
                    CLS_LOAD, CLS_STORE: begin
                        w_issue      = 1'b1;
                        w_retire     = 1'b0;
                        w_pc_next    = w_pc_inc;
                        w_next_state = ST_MEM;
                    end
                    CLS_IMM: begin
                        w_acc_next = w_alu_res;
                        w_pc_next  = w_pc_inc;
                    end
                    CLS_JUMP:
                        w_pc_next = w_jump_taken ? w_operand[PC_W-1:0] : w_pc_inc;
                    CLS_EXIT:
                        w_next_state = ST_HALT;
                    default:
                        w_pc_next = w_pc_inc;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = ST_RUN;
                    if (op_class(r_mem_op) == CLS_LOAD) begin
                        w_acc_next = w_alu_res;
                    end
                end
            end
            default: begin
                w_next_state = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request fields are captured only at issue, so they stay frozen through wait states.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_pc        <= '0;
            r_acc       <= '0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_op    <= OP_NOP;
        end else begin
            r_pc  <= w_pc_next;
            r_acc <= w_acc_next;
            if (w_issue) begin
                r_mem_write <= (w_cls == CLS_STORE);
                r_mem_addr  <= w_operand[ADDR_W-1:0];
                r_mem_wdata <= r_acc;
                r_mem_op    <= w_op;
            end
        end
    end

    assign imem_addr = r_pc;
    assign mem_valid = (r_state == ST_MEM);
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign acc       = r_acc;
    assign halted    = (r_state == ST_HALT);

`ifdef ACC_CORE_TRACE_EN
    logic [PC_W-1:0]   r_mem_pc;
    logic [15:0]       r_mem_instr;
    logic              r_trace_valid;
    logic [PC_W-1:0]   r_trace_pc;
    logic [15:0]       r_trace_instr;
    logic [DATA_W-1:0] r_trace_acc;

    // A memory op retires at its handshake, so its own pc/instr are kept from issue.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_mem_pc      <= '0;
            r_mem_instr   <= '0;
            r_trace_valid <= 1'b0;
            r_trace_pc    <= '0;
            r_trace_instr <= '0;
            r_trace_acc   <= '0;
        end else begin
            if (w_issue) begin
                r_mem_pc    <= r_pc;
                r_mem_instr <= imem_data;
            end
            r_trace_valid <= w_retire;
            if (w_retire) begin
                r_trace_pc    <= (r_state == ST_MEM) ? r_mem_pc    : r_pc;
                r_trace_instr <= (r_state == ST_MEM) ? r_mem_instr : imem_data;
                r_trace_acc   <= w_acc_next;
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_instr = r_trace_instr;
    assign trace_acc   = r_trace_acc;
`endif

endmodule

// File: tb/tb_acc_core.sv
// Directed bench for acc_core: table of small programs plus hand-written
// sequences for wait states, stores, pc wrap and mid-transaction reset.
module tb_acc_core;

    localparam int DATA_W = 32;
    localparam int PC_W   = 4;
    localparam int ADDR_W = 8;

    logic              CLK = 1'b0;
    logic              RESETN;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;
    logic              mem_valid;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] acc;
    logic              halted;

    always #5 CLK = ~CLK;

    acc_core #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .mem_valid (mem_valid),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .acc       (acc),
        .halted    (halted)
    );

    // Program ROM and a data memory with a programmable number of wait states.
    logic [15:0] imem [16];
    assign imem_data = imem[imem_addr];

    int          waits = 0;
    int          wcnt;
    logic [31:0] wmem [256];
    logic        wval [256];

    function automatic logic [31:0] dflt(input logic [7:0] a);
        return (a == 8'h05) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(a);
    endfunction

    assign mem_rdata = wval[mem_addr] ? wmem[mem_addr] : dflt(mem_addr);
    assign mem_ready = mem_valid && (wcnt >= waits);

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wcnt <= 0;
            for (int i = 0; i < 256; i++) wval[i] <= 1'b0;
        end else if (mem_valid && mem_ready) begin
            wcnt <= 0;
            if (mem_write) begin
                wmem[mem_addr] <= mem_wdata;
                wval[mem_addr] <= 1'b1;
            end
        end else if (mem_valid) begin
            wcnt <= wcnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [5:0][15:0] p;
        logic [7:0]       w;
        logic [7:0]       cyc;
        logic [31:0]      acc;
        logic [3:0]       pc;
    } vec_t;

    function automatic vec_t mkv(input logic [15:0] p0, p1, p2, p3, p4, p5,
                                 input logic [7:0] w, cyc,
                                 input logic [31:0] a, input logic [3:0] pc);
        vec_t t;
        t.p[0] = p0; t.p[1] = p1; t.p[2] = p2;
        t.p[3] = p3; t.p[4] = p4; t.p[5] = p5;
        t.w = w; t.cyc = cyc; t.acc = a; t.pc = pc;
        return t;
    endfunction

    task automatic do_reset(input logic [5:0][15:0] p, input int w);
        RESETN = 1'b0;
        waits  = w;
        for (int i = 0; i < 16; i++) imem[i] = (i < 6) ? p[i] : 16'h0000;
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    localparam int NV = 17;
    vec_t vecs [NV];
    vec_t t;
    int   n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mkv(16'h0879, 16'h0201, 16'h1300, 16'h0, 16'h0, 16'h0, 0, 3, 32'h0000007A, 2);
        vecs[1]  = mkv(16'h0810, 16'h0411, 16'h1300, 16'h0, 16'h0, 16'h0, 0, 3, 32'hFFFFFFFF, 2);
        vecs[2]  = mkv(16'h0801, 16'h0521, 16'h1300, 16'h0, 16'h0, 16'h0, 0, 3, 32'h00000002, 2);
        vecs[3]  = mkv(16'h0880, 16'h0603, 16'h1300, 16'h0, 16'h0, 16'h0, 0, 3, 32'h00000010, 2);
        vecs[4]  = mkv(16'h08F0, 16'h0B3C, 16'h1300, 16'h0, 16'h0, 16'h0, 0, 3, 32'h00000030, 2);
        vecs[5]  = mkv(16'h08F0, 16'h0D0F, 16'h0FFF, 16'h1300, 16'h0, 16'h0, 0, 4, 32'h00000000, 3);
        vecs[6]  = mkv(16'h0705, 16'h0201, 16'h1300, 16'h0, 16'h0, 16'h0, 2, 6, 32'hDEADBEF0, 2);
        vecs[7]  = mkv(16'h0802, 16'h0103, 16'h1300, 16'h0, 16'h0, 16'h0, 0, 4, 32'h10000005, 2);
        vecs[8]  = mkv(16'h0800, 16'h0304, 16'h1300, 16'h0, 16'h0, 16'h0, 1, 5, 32'hEFFFFFFC, 2);
        vecs[9]  = mkv(16'h08FF, 16'h0A07, 16'h1300, 16'h0, 16'h0, 16'h0, 0, 4, 32'h00000007, 2);
        vecs[10] = mkv(16'h0820, 16'h0C06, 16'h0E06, 16'h1300, 16'h0, 16'h0, 1, 8, 32'h00000020, 3);
        vecs[11] = mkv(16'h0800, 16'h1103, 16'h0855, 16'h1300, 16'h0, 16'h0, 0, 3, 32'h00000000, 3);
        vecs[12] = mkv(16'h0801, 16'h1103, 16'h1204, 16'h0855, 16'h1300, 16'h0, 0, 4, 32'h00000001, 4);
        vecs[13] = mkv(16'h1003, 16'h0811, 16'h1300, 16'h0822, 16'h1002, 16'h0, 0, 4, 32'h00000022, 2);
        vecs[14] = mkv(16'h0805, 16'h14FF, 16'hFF00, 16'h1300, 16'h0, 16'h0, 0, 4, 32'h00000005, 3);
        vecs[15] = mkv(16'h080F, 16'h0908, 16'h0800, 16'h0708, 16'h1300, 16'h0, 1, 9, 32'h0000000F, 4);
        vecs[16] = mkv(16'h0801, 16'h051F, 16'h1300, 16'h0, 16'h0, 16'h0, 0, 3, 32'h80000000, 2);

        // Reset state
        RESETN = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
        #1;
        check("reset acc", acc, 32'h0);
        check("reset pc", 32'(imem_addr), 32'h0);
        check("reset mem_valid", 32'(mem_valid), 32'h0);
        check("reset mem_write", 32'(mem_write), 32'h0);
        check("reset mem_addr", 32'(mem_addr), 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset halted", 32'(halted), 32'h0);

        // Table of programs run to EXIT
        for (int v = 0; v < NV; v++) begin
            do_reset(vecs[v].p, int'(vecs[v].w));
            n = 0;
            while (!halted && n < 200) begin
                step();
                n++;
            end
            check($sformatf("v%0d halted", v), 32'(halted), 32'h1);
            check($sformatf("v%0d cycles", v), 32'(n), 32'(vecs[v].cyc));
            check($sformatf("v%0d acc", v), acc, vecs[v].acc);
            check($sformatf("v%0d pc", v), 32'(imem_addr), 32'(vecs[v].pc));
        end

        // LOAD with three wait states: request frozen for four cycles
        t = mkv(16'h0705, 16'h1300, 16'h0, 16'h0, 16'h0, 16'h0, 3, 0, 0, 0);
        do_reset(t.p, int'(t.w));
        step();
        check("ldw pc after decode", 32'(imem_addr), 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            check($sformatf("ldw valid c%0d", k), 32'(mem_valid), 32'h1);
            check($sformatf("ldw addr c%0d", k), 32'(mem_addr), 32'h05);
            check($sformatf("ldw write c%0d", k), 32'(mem_write), 32'h0);
            check($sformatf("ldw acc c%0d", k), acc, 32'h0);
        end
        step();
        check("ldw valid after hs", 32'(mem_valid), 32'h0);
        check("ldw acc after hs", acc, 32'hDEADBEEF);
        step();
        check("ldw halted", 32'(halted), 32'h1);
        check("ldw pc at exit", 32'(imem_addr), 32'h1);

        // STORE request fields
        t = mkv(16'h080F, 16'h0908, 16'h1300, 16'h0, 16'h0, 16'h0, 1, 0, 0, 0);
        do_reset(t.p, int'(t.w));
        step();
        check("st acc loadi", acc, 32'h0F);
        step();
        check("st valid", 32'(mem_valid), 32'h1);
        check("st write", 32'(mem_write), 32'h1);
        check("st addr", 32'(mem_addr), 32'h08);
        check("st wdata", mem_wdata, 32'h0000000F);
        step();
        check("st wdata held", mem_wdata, 32'h0000000F);
        check("st valid held", 32'(mem_valid), 32'h1);
        step();
        check("st valid after hs", 32'(mem_valid), 32'h0);
        check("st acc unchanged", acc, 32'h0F);
        check("st memory written", wval[8] ? wmem[8] : 32'hFFFF_FFFF, 32'h0000000F);

        // pc wrap over an all-NOP program
        t = mkv(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0);
        do_reset(t.p, 0);
        repeat (15) step();
        check("wrap pc 15", 32'(imem_addr), 32'hF);
        step();
        check("wrap pc 0", 32'(imem_addr), 32'h0);
        check("wrap not halted", 32'(halted), 32'h0);

        // Reset asserted while a request is outstanding
        t = mkv(16'h0833, 16'h0705, 16'h1300, 16'h0, 16'h0, 16'h0, 20, 0, 0, 0);
        do_reset(t.p, int'(t.w));
        step();
        check("rst acc before", acc, 32'h33);
        step();
        check("rst valid before", 32'(mem_valid), 32'h1);
        #2;
        RESETN = 1'b0;
        #1;
        check("rst valid async drop", 32'(mem_valid), 32'h0);
        check("rst acc cleared", acc, 32'h0);
        check("rst pc cleared", 32'(imem_addr), 32'h0);
        @(negedge CLK);
        RESETN = 1'b1;
        #1;
        check("rst no request after release", 32'(mem_valid), 32'h0);
        step();
        check("rst redecode loadi valid", 32'(mem_valid), 32'h0);
        check("rst redecode loadi acc", acc, 32'h33);
        step();
        check("rst redecode load valid", 32'(mem_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_core.md
# acc_core

Parametrised accumulator processor core, successor to the fixed 32-bit/4-bit-PC accumulator controller. It fetches 16-bit instructions (8-bit opcode, 8-bit operand) from an external combinational instruction port and executes them against a single accumulator. Data-memory traffic uses a valid/ready handshake with arbitrary wait states instead of a fixed one-cycle bus. The core sits between the program ROM and the data bus of the accelerator tile.

## Interface
- DATA_W, 32, accumulator and data-bus width (≥ 8, power of two)
- PC_W, 4, program-counter width (1..8)
- ADDR_W, 8, data-memory address width (≤ 8; taken from the low bits of the operand)
- CLK  in  1  clock, rising edge
- RESETN  in  1  asynchronous active-low reset
- imem_addr  out  PC_W  instruction address, equal to pc
- imem_data  in  16  instruction at imem_addr, combinational, same cycle
- mem_valid  out  1  data request valid
- mem_write  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  request accepted / read data valid
- mem_rdata  in  DATA_W  read data, sampled when mem_valid & mem_ready
- acc  out  DATA_W  accumulator
- halted  out  1  EXIT executed

## Operation
- Opcodes (imm = operand zero-extended to DATA_W): 00 NOP; 01 ADD [m]; 02 ADDI; 03 SUB [m]; 04 SUBI; 05 SHL imm; 06 SHR imm (logical); 07 LOAD [m]; 08 LOADI; 09 STORE [m]; 0A AND [m]; 0B ANDI; 0C OR [m]; 0D ORI; 0E XOR [m]; 0F XORI; 10 JMP; 11 JZ (acc==0); 12 JNZ; 13 EXIT; all others execute as NOP.
- Memory ops: address = operand[ADDR_W-1:0]. Jumps: target = operand[PC_W-1:0]. Shifts: amount = operand[$clog2(DATA_W)-1:0].
- Arithmetic is modulo 2^DATA_W; no flags.
- FSM states: RUN, MEM, HALT.
- RUN: decode imem_data. Non-memory op: update acc/pc in one cycle; pc = pc+1, wrapping from 2^PC_W-1 to 0, unless a jump is taken. Memory op: register request (mem_valid=1, mem_write, mem_addr, mem_wdata=acc), pc = pc+1, latch op kind, go to MEM. EXIT: go to HALT, pc unchanged.
- MEM: hold every request field stable until mem_ready=1 at a rising edge. On that edge: mem_valid=0; for a load-class op, acc = f(acc, mem_rdata) (LOAD: acc = mem_rdata); for STORE, acc unchanged; go to RUN.
- HALT: halted=1, no fetch side effects, mem_valid=0; left only by reset.
- mem_ready is ignored while mem_valid=0.

## Timing
- Reset values: pc=0, acc=0, mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, halted=0, state RUN.
- Reset asserted mid-transaction drops mem_valid immediately (asynchronously); the request is abandoned.
- Non-memory instruction: 1 cycle. Memory instruction: 2 cycles plus one per cycle mem_ready is low.
- mem_valid rises on the edge that ends the decode cycle. The result is visible on acc one edge after the handshake. The next instruction decodes in the cycle following the handshake edge.
- Jump taken in cycle N: imem_addr equals the target after edge N.

## Configuration
- ACC_CORE_TRACE_EN defined: adds outputs trace_valid (1), trace_pc (PC_W), trace_instr (16), trace_acc (DATA_W). These are registered and pulse for one cycle per retired instruction; a memory op retires on its handshake edge. trace_acc holds the post-retire acc and trace_pc holds the instruction's own address. They reset to 0.
- Undefined: trace ports and logic are absent; all other behaviour is identical.

## Structure
- acc_pkg: opcode localparams/enum, FSM state enum, helper function classifying an opcode as load-class/store/immediate/jump.
- Sub-module acc_alu: combinational f(op, acc, operand) used by both the RUN immediate path and the MEM completion path.
- acc_core holds the FSM, pc, acc, request registers and the optional trace.

## Test plan
- Program LOADI 0x79; ADDI 0x01; EXIT with DATA_W=32 -> acc=0x7A, halted=1 after 3 cycles, pc=2.
- LOAD [0x05] with mem_ready held low 3 cycles, mem_rdata=0xDEADBEEF -> mem_valid/addr/write stable 4 cycles, acc=0xDEADBEEF one edge after the handshake, total 5 cycles.
- LOADI 0x0F; STORE [0x08] -> request with mem_write=1, mem_addr=0x08, mem_wdata=0x0000000F; acc remains 0x0F.
- LOADI 0x00; JZ 0x7; JNZ 0x2 at addresses 0..2 -> pc=7 after JZ; with acc=1, JNZ jumps to 2 and JZ falls through.
- PC_W=4, 15 NOPs then one more -> pc wraps 15->0. SHL by operand 0x21 with DATA_W=32 -> shift of 1.
- RESETN low while mem_valid=1 -> mem_valid=0 immediately; after release pc=0, acc=0, no request until re-decoded.
